riscv_id: RTL and testbench
===========================

Name: riscv_id

Overview:
- Decode stage of the 5-stage RV32I core; sits directly downstream of the fetch stage.
- Consumes the fetched pc/instruction pair and decodes it.
- Reads the register file combinationally and detects load-use hazards.
- Resolves JAL early as the ID-stage jump back to fetch.
- Registers a decoded bundle into the ID/EX pipeline register.

Parameters:
- JMP_SQUASH, 1, number of incoming instructions (0 or 1) killed in the cycle after o_id_jmp.
- ZERO_IS_BUBBLE, 1, when 1 an all-zero i_instr is treated as a bubble (not valid, not illegal).

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk
- i_pc  in  32  pc of i_instr, from fetch
- i_instr  in  32  fetched instruction (0 = bubble)
- i_flush  in  1  EX-stage redirect; kill the ID content
- i_ex_stall  in  1  downstream hold request
- i_ex_rd  in  5  rd of the instruction currently in EX
- i_ex_mem_rd  in  1  instruction in EX is a load
- i_rs1_data  in  32  register file read data, port 1
- i_rs2_data  in  32  register file read data, port 2
- o_rs1_addr  out  5  i_instr[19:15], combinational
- o_rs2_addr  out  5  i_instr[24:20], combinational
- o_if_run  out  1  1 = fetch may advance; 0 = fetch must hold pc/instr
- o_id_jmp  out  1  JAL taken in ID, combinational
- o_id_target  out  32  i_pc + J-immediate
- o_ex_valid  out  1  registered: bundle holds a real instruction
- o_ex_pc  out  32  registered pc
- o_ex_alu_op  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB
- o_ex_use_imm  out  1  ALU operand B = immediate
- o_ex_use_pc  out  1  ALU operand A = pc (AUIPC, JAL, JALR link)
- o_ex_imm  out  32  sign-extended immediate
- o_ex_rs1_data  out  32  registered operand
- o_ex_rs2_data  out  32  registered operand
- o_ex_rd  out  5  destination register
- o_ex_rd_we  out  1  write-back enable; forced 0 when rd = 0
- o_ex_mem_rd  out  1  load
- o_ex_mem_wr  out  1  store
- o_ex_funct3  out  3  passed through for branch/load/store width
- o_ex_branch  out  1  conditional branch, resolved in EX
- o_ex_jalr  out  1  JALR, resolved in EX
- o_ex_illegal  out  1  unknown opcode/funct

Behaviour:
- Reset (rst_n = 0 at posedge): all o_ex_* registers cleared to 0, squash counter cleared. While rst_n = 0, o_if_run = 1 and o_id_jmp = 0.
- in_valid = rst_n & ~(ZERO_IS_BUBBLE & i_instr == 0) & ~squash_active.
- Decoded opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, plus MISC-MEM as a NOP with valid = 1.
- Anything else, including i_instr[1:0] != 2'b11:
  - o_ex_illegal = 1, valid = 1.
  - rd_we, mem_rd, mem_wr, branch and jalr all 0.
- Immediates: I, S, B, U and J formats, all sign-extended to 32 bits. Shift-immediate uses shamt = instr[24:20], and instr[30] selects SRA.
- LUI: PASSB with imm.
- JAL/JALR: link value computed in EX as pc + 4.
- Hazard: hz = in_valid & i_ex_mem_rd & (i_ex_rd != 0) & ((rs1 used & rs1 == i_ex_rd) | (rs2 used & rs2 == i_ex_rd)).
  - rs1 is used by all opcodes except LUI, AUIPC and JAL.
  - rs2 is used by OP, BRANCH and STORE.
- o_if_run = ~(i_ex_stall | hz) | i_flush.
- o_id_jmp = in_valid & opcode == JAL & ~i_flush & ~i_ex_stall & ~hz. Address arithmetic is mod 2^32.
- Register update priority at posedge:
  1. Reset.
  2. i_flush: bubble (all o_ex_* = 0), squash cleared.
  3. i_ex_stall: all o_ex_* hold.
  4. hz: bubble inserted; the current input stays presented because fetch holds.
  5. Otherwise: capture the decoded bundle with o_ex_valid = in_valid.
- Squash: o_id_jmp = 1 at a posedge with JMP_SQUASH = 1 sets squash_active for exactly one following accepted input. That input produces a bubble. i_flush clears squash_active.
- Latency: 1 cycle from i_instr to o_ex_*. Throughput: 1 instruction per cycle without hazards.
- A bubble drives valid and every control bit to 0; data fields are 0.

Test Plan:
- ADDI x1,x0,5 (0x00500093) at pc 0x100 -> next cycle:
  - o_ex_valid = 1, alu_op = 0, use_imm = 1, imm = 5
  - rd = 1, rd_we = 1, pc = 0x100
- JAL x1,+16 (0x010000EF) at pc 0x200 -> same cycle o_id_jmp = 1, o_id_target = 0x210. Next cycle:
  - EX bundle has rd = 1, use_pc = 1, pc = 0x200
  - the following input (e.g. 0x00500093) yields o_ex_valid = 0
- i_ex_mem_rd = 1, i_ex_rd = 5, ID holds add x6,x5,x7 (0x00728333) ->
  - o_if_run = 0, bubble into EX
  - next cycle (ex_mem_rd = 0) the add issues with rd = 6
- i_flush = 1 with the JAL present -> o_id_jmp = 0, o_if_run = 1, o_ex_valid = 0 next cycle.
- i_instr = 0xFFFFFFFF -> o_ex_illegal = 1, valid = 1, rd_we = mem_rd = mem_wr = 0. i_instr = 0 -> o_ex_valid = 0, illegal = 0.
- i_ex_stall = 1 for 3 cycles -> o_ex_* constant, o_if_run = 0. Then assert rst_n = 0 for one cycle -> all o_ex_* = 0 at the next posedge.

Source files
------------

// File: rtl/riscv_id.sv
// riscv_id: RV32I decode stage. Decodes the fetched instruction, reads the
// register file combinationally, detects load-use hazards, resolves JAL in
// ID and registers the decoded bundle into the ID/EX pipeline register.
module riscv_id #(
  parameter int unsigned JMP_SQUASH     = 1,
  parameter bit          ZERO_IS_BUBBLE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_instr,
  input  logic        i_flush,
  input  logic        i_ex_stall,
  input  logic [4:0]  i_ex_rd,
  input  logic        i_ex_mem_rd,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  output logic [4:0]  o_rs1_addr,
  output logic [4:0]  o_rs2_addr,
  output logic        o_if_run,
  output logic        o_id_jmp,
  output logic [31:0] o_id_target,
  output logic        o_ex_valid,
  output logic [31:0] o_ex_pc,
  output logic [3:0]  o_ex_alu_op,
  output logic        o_ex_use_imm,
  output logic        o_ex_use_pc,
  output logic [31:0] o_ex_imm,
  output logic [31:0] o_ex_rs1_data,
  output logic [31:0] o_ex_rs2_data,
  output logic [4:0]  o_ex_rd,
  output logic        o_ex_rd_we,
  output logic        o_ex_mem_rd,
  output logic        o_ex_mem_wr,
  output logic [2:0]  o_ex_funct3,
  output logic        o_ex_branch,
  output logic        o_ex_jalr,
  output logic        o_ex_illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [3:0]  alu_op;
    logic        use_imm;
    logic        use_pc;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic        rd_we;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  funct3;
    logic        branch;
    logic        jalr;
    logic        illegal;
  } bundle_t;

  // Register-register / register-immediate ALU selection by funct3.
  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_of = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_of = ALU_SLL;
      3'b010:  alu_of = ALU_SLT;
      3'b011:  alu_of = ALU_SLTU;
      3'b100:  alu_of = ALU_XOR;
      3'b101:  alu_of = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_of = ALU_OR;
      default: alu_of = ALU_AND;
    endcase
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        squash_q;
  logic        in_valid;
  logic        rs1_used, rs2_used;
  logic        hz;
  bundle_t     dec, dec_b, ex_q;

  assign opcode = i_instr[6:0];
  assign funct3 = i_instr[14:12];
  assign funct7 = i_instr[31:25];
  assign rd     = i_instr[11:7];

  assign imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign imm_u = {i_instr[31:12], 12'b0};
  assign imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

  assign o_rs1_addr  = i_instr[19:15];
  assign o_rs2_addr  = i_instr[24:20];
  assign o_id_target = i_pc + imm_j;

  assign in_valid = rst_n & ~(ZERO_IS_BUBBLE & (i_instr == '0)) & ~squash_q;

  // Instruction decode into the next ID/EX bundle.
  always_comb begin
    dec          = '0;
    dec.valid    = 1'b1;
    dec.pc       = i_pc;
    dec.rs1_data = i_rs1_data;
    dec.rs2_data = i_rs2_data;
    dec.rd       = rd;
    dec.funct3   = funct3;
    dec.alu_op   = ALU_ADD;
    rs1_used     = 1'b1;
    rs2_used     = 1'b0;
    case (opcode)
      OPC_LUI: begin
        rs1_used    = 1'b0;
        dec.alu_op  = ALU_PASSB;
        dec.use_imm = 1'b1;
        dec.imm     = imm_u;
        dec.rd_we   = 1'b1;
      end
      OPC_AUIPC: begin
        rs1_used    = 1'b0;
        dec.use_pc  = 1'b1;
        dec.use_imm = 1'b1;
        dec.imm     = imm_u;
        dec.rd_we   = 1'b1;
      end
      OPC_JAL: begin
        rs1_used    = 1'b0;
        dec.use_pc  = 1'b1;
        dec.use_imm = 1'b1;
        dec.imm     = imm_j;
        dec.rd_we   = 1'b1;
      end
      OPC_JALR: begin
        dec.use_pc  = 1'b1;
        dec.use_imm = 1'b1;
        dec.imm     = imm_i;
        dec.rd_we   = 1'b1;
        dec.jalr    = 1'b1;
        dec.illegal = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        rs2_used    = 1'b1;
        dec.imm     = imm_b;
        dec.branch  = 1'b1;
        dec.alu_op  = funct3[2] ? (funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
        dec.illegal = (funct3[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        dec.use_imm = 1'b1;
        dec.imm     = imm_i;
        dec.rd_we   = 1'b1;
        dec.mem_rd  = 1'b1;
        dec.illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        rs2_used    = 1'b1;
        dec.use_imm = 1'b1;
        dec.imm     = imm_s;
        dec.mem_wr  = 1'b1;
        dec.illegal = (funct3[2] || (funct3[1:0] == 2'b11));
      end
      OPC_OPIMM: begin
        dec.use_imm = 1'b1;
        dec.rd_we   = 1'b1;
        if (funct3[1:0] == 2'b01) begin
          dec.imm     = {27'b0, i_instr[24:20]};
          dec.alu_op  = alu_of(funct3, i_instr[30]);
          dec.illegal = funct3[2] ? ({funct7[6], funct7[4:0]} != 6'b0) : (funct7 != 7'b0);
        end else begin
          dec.imm    = imm_i;
          dec.alu_op = alu_of(funct3, 1'b0);
        end
      end
      OPC_OP: begin
        rs2_used    = 1'b1;
        dec.rd_we   = 1'b1;
        dec.alu_op  = alu_of(funct3, i_instr[30]);
        dec.illegal = (funct7 == 7'b0100000) ? !((funct3 == 3'b000) || (funct3 == 3'b101))
                                              : (funct7 != 7'b0);
      end
      OPC_MISC: ;
      default: dec.illegal = 1'b1;
    endcase
    if (dec.illegal) begin
      dec.alu_op  = ALU_ADD;
      dec.use_imm = 1'b0;
      dec.use_pc  = 1'b0;
      dec.imm     = '0;
      dec.rd_we   = 1'b0;
      dec.mem_rd  = 1'b0;
      dec.mem_wr  = 1'b0;
      dec.branch  = 1'b0;
      dec.jalr    = 1'b0;
    end
    if (rd == 5'd0) dec.rd_we = 1'b0;
    dec_b = in_valid ? dec : '0;
  end

  // Load-use hazard, fetch run control and early JAL redirect.
  always_comb begin
    hz = in_valid & i_ex_mem_rd & (i_ex_rd != 5'd0) &
         ((rs1_used & (o_rs1_addr == i_ex_rd)) | (rs2_used & (o_rs2_addr == i_ex_rd)));
    o_if_run = ~rst_n | ~(i_ex_stall | hz) | i_flush;
    o_id_jmp = in_valid & (opcode == OPC_JAL) & ~i_flush & ~i_ex_stall & ~hz;
  end

  // ID/EX register and post-jump squash flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q     <= '0;
      squash_q <= 1'b0;
    end else if (i_flush) begin
      ex_q     <= '0;
      squash_q <= 1'b0;
    end else if (i_ex_stall) begin
      ex_q     <= ex_q;
      squash_q <= squash_q;
    end else if (hz) begin
      ex_q     <= '0;
      squash_q <= squash_q;
    end else begin
      ex_q     <= dec_b;
      squash_q <= o_id_jmp && (JMP_SQUASH != 0);
    end
  end

  assign o_ex_valid    = ex_q.valid;
  assign o_ex_pc       = ex_q.pc;
  assign o_ex_alu_op   = ex_q.alu_op;
  assign o_ex_use_imm  = ex_q.use_imm;
  assign o_ex_use_pc   = ex_q.use_pc;
  assign o_ex_imm      = ex_q.imm;
  assign o_ex_rs1_data = ex_q.rs1_data;
  assign o_ex_rs2_data = ex_q.rs2_data;
  assign o_ex_rd       = ex_q.rd;
  assign o_ex_rd_we    = ex_q.rd_we;
  assign o_ex_mem_rd   = ex_q.mem_rd;
  assign o_ex_mem_wr   = ex_q.mem_wr;
  assign o_ex_funct3   = ex_q.funct3;
  assign o_ex_branch   = ex_q.branch;
  assign o_ex_jalr     = ex_q.jalr;
  assign o_ex_illegal  = ex_q.illegal;

endmodule

// File: tb/tb_riscv_id.sv
// tb_riscv_id: directed vectors with hand-computed expectations for riscv_id.
module tb_riscv_id;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_pc, i_instr;
  logic        i_flush, i_ex_stall;
  logic [4:0]  i_ex_rd;
  logic        i_ex_mem_rd;
  logic [31:0] i_rs1_data, i_rs2_data;
  logic [4:0]  o_rs1_addr, o_rs2_addr;
  logic        o_if_run, o_id_jmp;
  logic [31:0] o_id_target;
  logic        o_ex_valid;
  logic [31:0] o_ex_pc;
  logic [3:0]  o_ex_alu_op;
  logic        o_ex_use_imm, o_ex_use_pc;
  logic [31:0] o_ex_imm, o_ex_rs1_data, o_ex_rs2_data;
  logic [4:0]  o_ex_rd;
  logic        o_ex_rd_we, o_ex_mem_rd, o_ex_mem_wr;
  logic [2:0]  o_ex_funct3;
  logic        o_ex_branch, o_ex_jalr, o_ex_illegal;

  int unsigned errors = 0;
  int unsigned checks = 0;

  riscv_id #(.JMP_SQUASH(1), .ZERO_IS_BUBBLE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .i_pc(i_pc), .i_instr(i_instr),
    .i_flush(i_flush), .i_ex_stall(i_ex_stall), .i_ex_rd(i_ex_rd),
    .i_ex_mem_rd(i_ex_mem_rd), .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
    .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr), .o_if_run(o_if_run),
    .o_id_jmp(o_id_jmp), .o_id_target(o_id_target), .o_ex_valid(o_ex_valid),
    .o_ex_pc(o_ex_pc), .o_ex_alu_op(o_ex_alu_op), .o_ex_use_imm(o_ex_use_imm),
    .o_ex_use_pc(o_ex_use_pc), .o_ex_imm(o_ex_imm), .o_ex_rs1_data(o_ex_rs1_data),
    .o_ex_rs2_data(o_ex_rs2_data), .o_ex_rd(o_ex_rd), .o_ex_rd_we(o_ex_rd_we),
    .o_ex_mem_rd(o_ex_mem_rd), .o_ex_mem_wr(o_ex_mem_wr), .o_ex_funct3(o_ex_funct3),
    .o_ex_branch(o_ex_branch), .o_ex_jalr(o_ex_jalr), .o_ex_illegal(o_ex_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one cycle and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] pc, input logic [31:0] instr);
    i_pc    = pc;
    i_instr = instr;
    #1;
  endtask

  task automatic check_zero_bundle(input string tag);
    check({tag, ".valid"},  32'(o_ex_valid), 0);
    check({tag, ".pc"},     o_ex_pc, 0);
    check({tag, ".alu"},    32'(o_ex_alu_op), 0);
    check({tag, ".imm"},    o_ex_imm, 0);
    check({tag, ".rs1d"},   o_ex_rs1_data, 0);
    check({tag, ".rd"},     32'(o_ex_rd), 0);
    check({tag, ".rd_we"},  32'(o_ex_rd_we), 0);
    check({tag, ".usei"},   32'(o_ex_use_imm), 0);
    check({tag, ".illeg"},  32'(o_ex_illegal), 0);
  endtask

  initial begin
    rst_n = 1'b0; i_pc = '0; i_instr = '0; i_flush = 1'b0; i_ex_stall = 1'b1;
    i_ex_rd = '0; i_ex_mem_rd = 1'b0; i_rs1_data = 32'h11; i_rs2_data = 32'h22;
    present(32'h200, 32'h010000EF);
    check("rst_if_run", 32'(o_if_run), 1);
    check("rst_id_jmp", 32'(o_id_jmp), 0);
    step();
    check_zero_bundle("rst");
    rst_n = 1'b1; i_ex_stall = 1'b0;

    // ADDI x1,x0,5
    present(32'h100, 32'h00500093);
    check("addi_rs1a", 32'(o_rs1_addr), 0);
    check("addi_rs2a", 32'(o_rs2_addr), 5);
    step();
    check("addi_valid", 32'(o_ex_valid), 1);
    check("addi_alu",   32'(o_ex_alu_op), 0);
    check("addi_usei",  32'(o_ex_use_imm), 1);
    check("addi_imm",   o_ex_imm, 5);
    check("addi_rd",    32'(o_ex_rd), 1);
    check("addi_rdwe",  32'(o_ex_rd_we), 1);
    check("addi_pc",    o_ex_pc, 32'h100);

    // JAL x1,+16 then squashed follower, then a normal instruction
    present(32'h200, 32'h010000EF);
    check("jal_jmp",    32'(o_id_jmp), 1);
    check("jal_target", o_id_target, 32'h210);
    check("jal_ifrun",  32'(o_if_run), 1);
    step();
    check("jal_valid",  32'(o_ex_valid), 1);
    check("jal_rd",     32'(o_ex_rd), 1);
    check("jal_usepc",  32'(o_ex_use_pc), 1);
    check("jal_pc",     o_ex_pc, 32'h200);
    present(32'h210, 32'h00500093);
    check("sq_jmp_off", 32'(o_id_jmp), 0);
    step();
    check("sq_valid",   32'(o_ex_valid), 0);
    present(32'h214, 32'h00500093);
    step();
    check("postsq_valid", 32'(o_ex_valid), 1);
    check("postsq_pc",    o_ex_pc, 32'h214);

    // Load-use hazard on rs1, rs2, none for rd=0 and for LUI
    i_ex_mem_rd = 1'b1; i_ex_rd = 5'd5;
    present(32'h300, 32'h00728333);
    check("hz_ifrun", 32'(o_if_run), 0);
    step();
    check("hz_bubble", 32'(o_ex_valid), 0);
    i_ex_rd = 5'd7; #1;
    check("hz_rs2_ifrun", 32'(o_if_run), 0);
    i_ex_rd = 5'd0; #1;
    check("hz_x0_ifrun", 32'(o_if_run), 1);
    i_ex_mem_rd = 1'b0; i_ex_rd = 5'd5; #1;
    check("nohz_ifrun", 32'(o_if_run), 1);
    step();
    check("add_valid", 32'(o_ex_valid), 1);
    check("add_rd",    32'(o_ex_rd), 6);
    check("add_usei",  32'(o_ex_use_imm), 0);
    check("add_rs1d",  o_ex_rs1_data, 32'h11);
    check("add_rs2d",  o_ex_rs2_data, 32'h22);
    i_ex_mem_rd = 1'b1; i_ex_rd = 5'd8;
    present(32'h304, 32'h123452B7);
    check("lui_ifrun", 32'(o_if_run), 1);
    step();
    check("lui_alu", 32'(o_ex_alu_op), 10);
    check("lui_imm", o_ex_imm, 32'h12345000);
    check("lui_rd",  32'(o_ex_rd), 5);
    i_ex_mem_rd = 1'b0; i_ex_rd = 5'd0;

    // Flush with JAL present, and flush clearing a pending squash
    i_flush = 1'b1;
    present(32'h200, 32'h010000EF);
    check("fl_jmp",   32'(o_id_jmp), 0);
    check("fl_ifrun", 32'(o_if_run), 1);
    step();
    check("fl_valid", 32'(o_ex_valid), 0);
    i_flush = 1'b0;
    step();
    check("jal2_valid", 32'(o_ex_valid), 1);
    i_flush = 1'b1;
    present(32'h210, 32'h00500093);
    step();
    i_flush = 1'b0;
    present(32'h400, 32'h00500093);
    step();
    check("flsq_valid", 32'(o_ex_valid), 1);

    // Illegal, bubble, store, rd=x0, SRAI, BNE
    present(32'h500, 32'hFFFFFFFF);
    step();
    check("ill_illeg", 32'(o_ex_illegal), 1);
    check("ill_valid", 32'(o_ex_valid), 1);
    check("ill_ctl", {28'b0, o_ex_rd_we, o_ex_mem_rd, o_ex_mem_wr, o_ex_branch}, 0);
    present(32'h504, 32'h00000001);
    step();
    check("ill2_illeg", 32'(o_ex_illegal), 1);
    present(32'h508, 32'h00000000);
    step();
    check("zero_valid", 32'(o_ex_valid), 0);
    check("zero_illeg", 32'(o_ex_illegal), 0);
    present(32'h50C, 32'h0020A423);
    step();
    check("sw_memwr", 32'(o_ex_mem_wr), 1);
    check("sw_rdwe",  32'(o_ex_rd_we), 0);
    check("sw_imm",   o_ex_imm, 8);
    check("sw_f3",    32'(o_ex_funct3), 2);
    present(32'h510, 32'h00100013);
    step();
    check("x0_valid", 32'(o_ex_valid), 1);
    check("x0_rdwe",  32'(o_ex_rd_we), 0);
    present(32'h514, 32'h4041D193);
    step();
    check("srai_alu", 32'(o_ex_alu_op), 7);
    check("srai_imm", o_ex_imm, 4);
    present(32'h518, 32'hFE209EE3);
    step();
    check("bne_imm",    o_ex_imm, 32'hFFFFFFFC);
    check("bne_branch", 32'(o_ex_branch), 1);
    check("bne_alu",    32'(o_ex_alu_op), 1);
    check("bne_rdwe",   32'(o_ex_rd_we), 0);

    // Stall holds bundle for 3 cycles, then reset clears it
    present(32'h600, 32'h00500093);
    step();
    i_ex_stall = 1'b1;
    present(32'h604, 32'h0020A423);
    for (int unsigned c = 0; c < 3; c++) begin
      check("st_ifrun", 32'(o_if_run), 0);
      step();
      check("st_valid", 32'(o_ex_valid), 1);
      check("st_pc",    o_ex_pc, 32'h600);
      check("st_imm",   o_ex_imm, 5);
      check("st_rdwe",  32'(o_ex_rd_we), 1);
    end
    rst_n = 1'b0; #1;
    check("rst2_ifrun", 32'(o_if_run), 1);
    step();
    check_zero_bundle("rst2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
